// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO that buffers bytes from a UART receiver and exposes the head as a show-ahead read port.
// Optional macro UART_RX_DROP_COUNT_EN adds an 8-bit saturating count of discarded bytes.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  ovf_clear
`ifdef UART_RX_DROP_COUNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  // Handshake: in_valid is a strobe with no backpressure; a byte leaves the
  // head on any cycle where rd_valid and rd_ready are both high.
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop, full, drop;

  always_comb begin
    pop  = (count_q != '0) && rd_ready;
    full = (count_q == DEPTH_CNT);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    push = in_valid && (!full || pop);
    drop = in_valid && !push;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    if (drop)           overflow_d = 1'b1;
    else if (ovf_clear) overflow_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left uninitialised; the pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_valid = (count_q != '0);
  assign count    = count_q;
  assign overflow = overflow_q;

`ifdef UART_RX_DROP_COUNT_EN
  logic [7:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop) begin
      if (ovf_clear)                  drop_count_d = 8'd1;
      else if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end else if (ovf_clear) begin
      drop_count_d = 8'd0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) drop_count_q <= 8'd0;
    else       drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic [7:0]    in_data;
  logic          in_valid;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DL:0]   count;
  logic          overflow;
  logic          ovf_clear;
`ifdef UART_RX_DROP_COUNT_EN
  logic [7:0]    drop_count;
`endif

  uart_rx_fifo #(.DEPTH_LOG2(DL)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .count      (count),
    .overflow   (overflow),
    .ovf_clear  (ovf_clear)
`ifdef UART_RX_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 CLK = ~CLK;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [7:0]  exp_q[$];
  logic        exp_ovf;
  int          exp_drops;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovf   = 1'b0;
    exp_drops = 0;
  endtask

  task automatic check_outputs();
    chk("rd_valid", 16'(rd_valid), 16'(exp_q.size() != 0));
    chk("count", 16'(count), 16'(exp_q.size()));
    chk("overflow", 16'(overflow), 16'(exp_ovf));
    if (exp_q.size() != 0) chk("rd_data", 16'(rd_data), 16'(exp_q[0]));
`ifdef UART_RX_DROP_COUNT_EN
    chk("drop_count", 16'(drop_count), 16'(exp_drops));
`endif
  endtask

  // One clock cycle: drive at the falling edge, check the pre-edge state,
  // then advance the model to what the coming rising edge should produce.
  task automatic step(input logic iv, input logic [7:0] d, input logic rr, input logic oc);
    bit do_pop, do_push;
    @(negedge CLK);
    in_valid  = iv;
    in_data   = d;
    rd_ready  = rr;
    ovf_clear = oc;
    #1;
    check_outputs();
    do_pop  = (exp_q.size() != 0) && rr;
    do_push = iv && ((exp_q.size() < DEPTH) || do_pop);
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(d);
    if (iv && !do_push) begin
      exp_ovf   = 1'b1;
      exp_drops = oc ? 1 : ((exp_drops < 255) ? exp_drops + 1 : 255);
    end else if (oc) begin
      exp_ovf   = 1'b0;
      exp_drops = 0;
    end
  endtask

  task automatic fill_to_full();
    while (exp_q.size() < DEPTH) step(1'b1, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    int pushed;
    RSTN      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    rd_ready  = 1'b0;
    ovf_clear = 1'b0;
    model_reset();
    #12;
    check_outputs();
    @(negedge CLK);
    RSTN = 1'b1;

    // Three bytes held, then read back-to-back.
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // rd_ready while empty, then push with rd_ready high (no same-cycle bypass).
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Seventeen bytes with no pops: the last one is dropped.
    for (int i = 0; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_after_17", 16'(overflow), 16'd1);
    drain();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Full plus simultaneous push/pop: nothing dropped, new byte read last.
    fill_to_full();
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Clear coincident with a drop keeps the flag; clear alone removes it.
    fill_to_full();
    step(1'b1, 8'hE1, 1'b0, 1'b0);
    step(1'b1, 8'hE2, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // Forty bytes streamed across the pointer wrap with rd_ready toggling.
    pushed = 0;
    for (int c = 0; c < 400 && pushed < 40; c++) begin
      logic iv;
      iv = ($urandom_range(0, 3) != 0) && (exp_q.size() < DEPTH);
      step(iv, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      if (iv) pushed++;
      chk("count_le_depth", 16'(count <= 5'(DEPTH)), 16'd1);
    end
    chk("stream_done", 16'(pushed), 16'd40);
    drain();

    // Unconstrained random traffic including drops and clears.
    for (int c = 0; c < 400; c++)
      step(1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
    drain();
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset between edges with five bytes held.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("count_before_rst", 16'(count), 16'd5);
    #1 RSTN = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #1 RSTN = 1'b1;
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock CLK, reset RSTN.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of the FIFO depth (DEPTH = 2**DEPTH_LOG2 entries of 8 bits).
REQ-003 Port CLK  input  1  system clock; all state SHALL change on its rising edge, except on reset.
REQ-004 Port RSTN  input  1  asynchronous active-low reset.
REQ-005 Port in_data  input  8  received byte from the UART receiver.
REQ-006 Port in_valid  input  1  single-cycle strobe; in_data is valid in that cycle; there is no backpressure.
REQ-007 Port rd_data  output  8  byte at the FIFO head.
REQ-008 Port rd_valid  output  1  high when the FIFO is non-empty.
REQ-009 Port rd_ready  input  1  consumer accepts rd_data.
REQ-010 Port count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
REQ-011 Port overflow  output  1  sticky flag; set when a byte is dropped.
REQ-012 Port ovf_clear  input  1  clears overflow.

Function
REQ-013 Push SHALL occur when in_valid=1 and either count<DEPTH or a pop occurs in the same cycle.
REQ-014 Pop SHALL occur when rd_valid=1 and rd_ready=1.
REQ-015 rd_data SHALL show the head entry combinationally, so the head is readable in the same cycle it is exposed.
REQ-016 rd_data SHALL be don't-care when rd_valid=0.
REQ-017 Write latency SHALL be 1 cycle: a byte pushed at edge N is visible on rd_data/rd_valid after edge N, with no bypass into the same cycle.
REQ-018 On push while empty with rd_ready=1, no pop SHALL occur in the push cycle.
REQ-019 Read and write pointers SHALL be DEPTH_LOG2 bits and wrap modulo DEPTH.
REQ-020 count SHALL change as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-021 When full with in_valid=1 and rd_ready=1, both the push and the pop SHALL occur, count SHALL stay DEPTH, and no byte SHALL be dropped.
REQ-022 When full with in_valid=1 and no pop, the incoming byte SHALL be discarded, FIFO contents SHALL be unchanged, and overflow SHALL be set on the next edge.
REQ-023 rd_ready while empty SHALL have no effect: no pointer change and count stays 0.
REQ-024 ovf_clear=1 SHALL clear overflow on the next edge.
REQ-025 If ovf_clear=1 and a drop occur in the same cycle, overflow SHALL remain 1 (set wins).
REQ-026 Byte order SHALL be strict FIFO, and bytes SHALL never be duplicated.

Reset
REQ-027 RSTN=0 SHALL immediately set both pointers to 0, count=0, rd_valid=0 and overflow=0, independent of CLK.
REQ-028 Reset mid-operation SHALL discard all stored bytes, and the storage array need not be cleared.
REQ-029 After RSTN deasserts, the first in_valid strobe SHALL be accepted normally.

Configuration
REQ-030 With macro UART_RX_DROP_COUNT_EN defined, the block SHALL add output port drop_count (8 bits): +1 per discarded byte, saturating at 255, cleared by ovf_clear, and reset to 0.
REQ-031 If ovf_clear=1 and a drop occur in the same cycle with UART_RX_DROP_COUNT_EN defined, drop_count SHALL become 1.
REQ-032 Without UART_RX_DROP_COUNT_EN, port drop_count and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Scenario: DEPTH_LOG2=4; push 0x41,0x42,0x43 with rd_ready=0, then rd_ready=1 -> rd_data reads 0x41,0x42,0x43 on consecutive cycles, count goes 3->0, rd_valid falls after the third pop.
REQ-034 Scenario: push 17 bytes 0x00..0x10 with no pops -> count=16, overflow=1 after the 17th strobe, and reads return 0x00..0x0F (0x10 lost); with the macro defined, drop_count=1.
REQ-035 Scenario: fill to 16, then in_valid=1 with rd_ready=1 in the same cycle -> count stays 16, overflow stays 0, head advances, and the new byte is read last.
REQ-036 Scenario: push/pop across pointer wrap, 40 bytes streamed with rd_ready toggling -> output sequence equals input sequence and count never exceeds 16.
REQ-037 Scenario: overflow set, then ovf_clear coincident with another drop -> overflow remains 1; then ovf_clear alone -> overflow=0.
REQ-038 Scenario: RSTN pulsed low between clock edges with count=5 -> rd_valid and count drop to 0 immediately; the next strobed byte 0x55 is the next byte read.
